// File: rtl/dcachemem_assoc_if.sv
// Write-back stream from the cache array flush engine to the memory write-back path.
// A line transfers on any clock edge where wb_valid & wb_ready; the source holds wb_index/tag/data stable until then.
interface dcachemem_assoc_if #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 9,
    parameter int DATA_W = 64
);
    logic              wb_valid;
    logic              wb_ready;
    logic [IDX_W-1:0]  wb_index;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;

    modport master (output wb_valid, wb_index, wb_tag, wb_data, input wb_ready);
    modport slave  (input wb_valid, wb_index, wb_tag, wb_data, output wb_ready);
endinterface

// File: rtl/dcachemem_assoc.sv
// N-way set-associative data-cache array with true-LRU ages, dirty tracking, victim reporting
// and a flush engine that streams dirty lines over the write-back interface.
module dcachemem_assoc #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 9,
    parameter int DATA_W = 64,
    localparam int WAY_W = $clog2(WAYS),
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  index_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              wr_dirty,
    input  logic [DATA_W-1:0] data_in,
    output logic              hit,
    output logic [WAY_W-1:0]  hit_way,
    output logic [DATA_W-1:0] data_out,
    output logic [WAY_W-1:0]  victim_way,
    output logic [TAG_W-1:0]  victim_tag,
    output logic              victim_dirty,
    input  logic [IDX_W-1:0]  resp_index_in,
    input  logic [TAG_W-1:0]  resp_tag_in,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_data_out,
    input  logic              flush_req,
    input  logic              flush_inv,
    output logic              flush_busy,
    output logic              flush_done,
    dcachemem_assoc_if.master wb,
    output logic [1:0]        flush_state
);
    localparam int PTR_W = IDX_W + WAY_W;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic              inv_q;
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];

    logic [WAY_W-1:0]  resp_way;
    logic [WAY_W-1:0]  wr_target;
    logic [WAY_W-1:0]  touch_way;
    logic [WAY_W-1:0]  touch_age;
    logic              acc_en;
    logic [IDX_W-1:0]  ptr_set;
    logic [WAY_W-1:0]  ptr_way;
    logic              ptr_last;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        resp_hit   = 1'b0;
        resp_way   = '0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index_in][w] && tag_q[index_in][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (valid_q[resp_index_in][w] && tag_q[resp_index_in][w] == resp_tag_in) begin
                resp_hit = 1'b1;
                resp_way = WAY_W'(w);
            end
            if (age_q[index_in][w] == WAY_W'(WAYS - 1))
                victim_way = WAY_W'(w);
        end
        // Descending scan so the lowest-index invalid way overrides the LRU choice.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[index_in][w])
                victim_way = WAY_W'(w);
        end
    end

    assign victim_tag    = tag_q[index_in][victim_way];
    assign victim_dirty  = valid_q[index_in][victim_way] & dirty_q[index_in][victim_way];
    assign data_out      = data_q[index_in][hit ? hit_way : victim_way];
    assign resp_data_out = resp_hit ? data_q[resp_index_in][resp_way] : '0;

    assign acc_en    = (state == S_IDLE) && (wr_en || (rd_en && hit));
    assign wr_target = hit ? hit_way : victim_way;
    assign touch_way = wr_en ? wr_target : hit_way;
    assign touch_age = age_q[index_in][touch_way];

    assign ptr_set  = ptr[PTR_W-1:WAY_W];
    assign ptr_way  = ptr[WAY_W-1:0];
    assign ptr_last = &ptr;

    assign flush_busy  = (state != S_IDLE);
    assign flush_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
            state       <= S_IDLE;
            ptr         <= '0;
            inv_q       <= 1'b0;
            flush_done  <= 1'b0;
            wb.wb_valid <= 1'b0;
            wb.wb_index <= '0;
            wb.wb_tag   <= '0;
            wb.wb_data  <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc_en) begin
                        if (wr_en) begin
                            tag_q[index_in][wr_target]   <= tag_in;
                            data_q[index_in][wr_target]  <= data_in;
                            valid_q[index_in][wr_target] <= 1'b1;
                            dirty_q[index_in][wr_target] <= (hit & dirty_q[index_in][wr_target]) | wr_dirty;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == touch_way)
                                age_q[index_in][w] <= '0;
                            else if (age_q[index_in][w] < touch_age)
                                age_q[index_in][w] <= age_q[index_in][w] + 1'b1;
                        end
                    end
                    if (flush_req) begin
                        state <= S_SCAN;
                        ptr   <= '0;
                        inv_q <= flush_inv;
                    end
                end
                S_SCAN: begin
                    if (valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way]) begin
                        state       <= S_EMIT;
                        wb.wb_valid <= 1'b1;
                        wb.wb_index <= ptr_set;
                        wb.wb_tag   <= tag_q[ptr_set][ptr_way];
                        wb.wb_data  <= data_q[ptr_set][ptr_way];
                    end else begin
                        if (inv_q)
                            valid_q[ptr_set][ptr_way] <= 1'b0;
                        if (ptr_last) begin
                            state      <= S_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (wb.wb_ready) begin
                        wb.wb_valid               <= 1'b0;
                        dirty_q[ptr_set][ptr_way] <= 1'b0;
                        if (inv_q)
                            valid_q[ptr_set][ptr_way] <= 1'b0;
                        if (ptr_last) begin
                            state      <= S_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcachemem_assoc.sv
// Randomized bench for dcachemem_assoc against a recency-list model of the cache array.
module tb_dcachemem_assoc;
    localparam int WAYS   = 4;
    localparam int SETS   = 16;
    localparam int TAG_W  = 9;
    localparam int DATA_W = 64;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int EXP_W  = IDX_W + TAG_W + DATA_W;

    logic              clock;
    logic              reset_n;
    logic [IDX_W-1:0]  index_in;
    logic [TAG_W-1:0]  tag_in;
    logic              rd_en, wr_en, wr_dirty;
    logic [DATA_W-1:0] data_in;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [DATA_W-1:0] data_out;
    logic [WAY_W-1:0]  victim_way;
    logic [TAG_W-1:0]  victim_tag;
    logic              victim_dirty;
    logic [IDX_W-1:0]  resp_index_in;
    logic [TAG_W-1:0]  resp_tag_in;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data_out;
    logic              flush_req, flush_inv, flush_busy, flush_done;
    logic [1:0]        flush_state;

    dcachemem_assoc_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) wb_if ();

    dcachemem_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .index_in(index_in), .tag_in(tag_in), .rd_en(rd_en), .wr_en(wr_en),
        .wr_dirty(wr_dirty), .data_in(data_in),
        .hit(hit), .hit_way(hit_way), .data_out(data_out),
        .victim_way(victim_way), .victim_tag(victim_tag), .victim_dirty(victim_dirty),
        .resp_index_in(resp_index_in), .resp_tag_in(resp_tag_in),
        .resp_hit(resp_hit), .resp_data_out(resp_data_out),
        .flush_req(flush_req), .flush_inv(flush_inv),
        .flush_busy(flush_busy), .flush_done(flush_done),
        .wb(wb_if), .flush_state(flush_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // scoreboard state and reference model
    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [DATA_W-1:0] m_data  [SETS][WAYS];
    int                m_list  [SETS][WAYS];  // recency order, position 0 = most recent

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = '0;
                m_data[s][w]  = '0;
                m_list[s][w]  = w;
            end
    endtask

    function automatic int m_find(input int s, input logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[s][w]) return w;
        return m_list[s][WAYS-1];
    endfunction

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++)
            if (m_list[s][i] == w) p = i;
        for (int i = p; i > 0; i--)
            m_list[s][i] = m_list[s][i-1];
        m_list[s][0] = w;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_lookup();
        int s  = int'(index_in);
        int hw = m_find(s, tag_in);
        int v  = m_victim(s);
        int rs = int'(resp_index_in);
        int rw = m_find(rs, resp_tag_in);
        check("hit", 64'(hit), 64'(hw >= 0));
        check("hit_way", 64'(hit_way), 64'(hw >= 0 ? hw : 0));
        check("victim_way", 64'(victim_way), 64'(v));
        check("victim_tag", 64'(victim_tag), 64'(m_tag[s][v]));
        check("victim_dirty", 64'(victim_dirty), 64'(m_valid[s][v] & m_dirty[s][v]));
        check("data_out", data_out, hw >= 0 ? m_data[s][hw] : m_data[s][v]);
        check("resp_hit", 64'(resp_hit), 64'(rw >= 0));
        check("resp_data_out", resp_data_out, rw >= 0 ? m_data[rs][rw] : 64'd0);
    endtask

    task automatic peek(input int idx, input int tag);
        index_in = IDX_W'(idx);
        tag_in   = TAG_W'(tag);
        #1;
    endtask

    task automatic access(input bit rd, input bit wr, input bit wd, input int idx, input int tag,
                          input logic [DATA_W-1:0] d);
        int hw, v, s;
        rd_en         = rd;
        wr_en         = wr;
        wr_dirty      = wd;
        index_in      = IDX_W'(idx);
        tag_in        = TAG_W'(tag);
        data_in       = d;
        resp_index_in = IDX_W'($urandom_range(0, SETS - 1));
        resp_tag_in   = TAG_W'($urandom_range(0, 7));
        #1;
        check_lookup();
        s  = idx;
        hw = m_find(s, TAG_W'(tag));
        v  = m_victim(s);
        tick();
        if (wr) begin
            int t = (hw >= 0) ? hw : v;
            m_dirty[s][t] = (hw >= 0) ? (m_dirty[s][t] | wd) : wd;
            m_valid[s][t] = 1;
            m_tag[s][t]   = TAG_W'(tag);
            m_data[s][t]  = d;
            m_touch(s, t);
        end else if (rd && hw >= 0) begin
            m_touch(s, hw);
        end
        rd_en = 0;
        wr_en = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        model_reset();
    endtask

    task automatic run_flush(input bit inv, input bit stall, input bit noise);
        int n_exp, n_hs, n_done, stall_cnt, cycles;
        bit first, prev_v, fin, rdy;
        logic [IDX_W-1:0]  p_idx;
        logic [TAG_W-1:0]  p_tag;
        logic [DATA_W-1:0] p_data;
        logic [EXP_W-1:0]  e;
        n_hs = 0; n_done = 0; stall_cnt = 0; cycles = 0;
        first = 1; prev_v = 0; fin = 0;
        p_idx = '0; p_tag = '0; p_data = '0;
        exp_q.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_dirty[s][w])
                    exp_q.push_back({IDX_W'(s), m_tag[s][w], m_data[s][w]});
        n_exp = exp_q.size();
        flush_req = 1;
        flush_inv = inv;
        tick();
        flush_req = 0;
        flush_inv = 0;
        while (!fin && cycles < 3000) begin
            cycles++;
            check("flush_busy", 64'(flush_busy), 64'd1);
            if (flush_done) begin
                n_done++;
                fin = 1;
            end
            if (wb_if.wb_valid) begin
                if (prev_v) begin
                    check("wb_index_stable", 64'(wb_if.wb_index), 64'(p_idx));
                    check("wb_tag_stable", 64'(wb_if.wb_tag), 64'(p_tag));
                    check("wb_data_stable", wb_if.wb_data, p_data);
                end
                if (stall && first && stall_cnt < 5) begin
                    rdy = 0;
                    stall_cnt++;
                end else begin
                    rdy = stall ? 1'b1 : 1'($urandom_range(0, 1));
                end
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check("wb_extra_line", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_index", 64'(wb_if.wb_index), 64'(e[DATA_W+TAG_W +: IDX_W]));
                        check("wb_tag", 64'(wb_if.wb_tag), 64'(e[DATA_W +: TAG_W]));
                        check("wb_data", wb_if.wb_data, e[DATA_W-1:0]);
                    end
                    n_hs++;
                    first  = 0;
                    prev_v = 0;
                end else begin
                    prev_v = 1;
                    p_idx  = wb_if.wb_index;
                    p_tag  = wb_if.wb_tag;
                    p_data = wb_if.wb_data;
                end
            end else begin
                rdy    = 1'($urandom_range(0, 1));
                prev_v = 0;
            end
            if (noise) begin
                wr_en    = 1'($urandom_range(0, 1));
                rd_en    = 1'($urandom_range(0, 1));
                wr_dirty = 1'($urandom_range(0, 1));
                index_in = IDX_W'($urandom_range(0, SETS - 1));
                tag_in   = TAG_W'($urandom_range(0, 7));
                data_in  = {$urandom, $urandom};
            end
            wb_if.wb_ready = rdy;
            tick();
        end
        wr_en = 0;
        rd_en = 0;
        wb_if.wb_ready = 0;
        check("flush_finished", 64'(fin), 64'd1);
        check("handshake_count", 64'(n_hs), 64'(n_exp));
        check("done_pulses", 64'(n_done), 64'd1);
        check("busy_after_flush", 64'(flush_busy), 64'd0);
        check("done_after_flush", 64'(flush_done), 64'd0);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_dirty[s][w] = 0;
                if (inv) m_valid[s][w] = 0;
            end
    endtask

    initial begin
        int wait_cyc;
        reset_n = 0;
        index_in = '0; tag_in = '0; rd_en = 0; wr_en = 0; wr_dirty = 0; data_in = '0;
        resp_index_in = '0; resp_tag_in = '0; flush_req = 0; flush_inv = 0;
        wb_if.wb_ready = 0;
        model_reset();
        repeat (2) tick();
        reset_n = 1;

        // reset state
        peek(0, 0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_victim_way", 64'(victim_way), 64'd0);
        check("rst_victim_dirty", 64'(victim_dirty), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_flush_busy", 64'(flush_busy), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_wb_valid", 64'(wb_if.wb_valid), 64'd0);
        check("rst_state", 64'(flush_state), 64'd0);

        // fills land in ways 0..3, then the oldest is the victim
        for (int t = 1; t <= 4; t++) access(0, 1, 0, 3, t, {$urandom, $urandom});
        for (int t = 1; t <= 4; t++) begin
            peek(3, t);
            check("fill_order_way", 64'(hit_way), 64'(t - 1));
        end
        peek(3, 5);
        check("t1_victim_way", 64'(victim_way), 64'd0);
        check("t1_victim_dirty", 64'(victim_dirty), 64'd0);
        access(0, 1, 0, 3, 5, {$urandom, $urandom});
        peek(3, 5);
        check("t1_replaced_way", 64'(hit_way), 64'd0);

        // read hits reorder LRU
        for (int t = 10; t <= 13; t++) access(0, 1, 0, 0, t, {$urandom, $urandom});
        access(1, 0, 0, 0, 12, '0);
        access(1, 0, 0, 0, 10, '0);
        peek(0, 99);
        check("t2_victim_way", 64'(victim_way), 64'd1);

        // dirty is sticky across a clean fill hit
        access(0, 1, 0, 5, 7, {$urandom, $urandom});
        access(0, 1, 1, 5, 7, {$urandom, $urandom});
        access(0, 1, 0, 5, 7, {$urandom, $urandom});
        for (int t = 20; t <= 22; t++) access(0, 1, 0, 5, t, {$urandom, $urandom});
        peek(5, 9'h1ff);
        check("t3_victim_way", 64'(victim_way), 64'd0);
        check("t3_victim_tag", 64'(victim_tag), 64'd7);
        check("t3_victim_dirty", 64'(victim_dirty), 64'd1);

        // random accesses against the model
        for (int i = 0; i < 400; i++)
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 7), {$urandom, $urandom});
        run_flush(0, 0, 0);
        for (int i = 0; i < 40; i++)
            access(1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 3), $urandom_range(0, 7), '0);

        // directed flush: three dirty lines, first one stalled
        do_reset();
        access(0, 1, 1, 1, 30, {$urandom, $urandom});
        access(0, 1, 0, 1, 31, {$urandom, $urandom});
        access(0, 1, 1, 4, 32, {$urandom, $urandom});
        access(0, 1, 1, 9, 33, {$urandom, $urandom});
        access(0, 1, 0, 9, 34, {$urandom, $urandom});
        check("t4_dirty_lines", 64'(exp_q.size()), 64'd0);
        run_flush(0, 1, 0);
        for (int t = 30; t <= 34; t++) begin
            access(1, 0, 0, (t == 30 || t == 31) ? 1 : (t == 32) ? 4 : 9, t, '0);
        end

        // invalidating flush with write noise
        for (int i = 0; i < 60; i++)
            access(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, SETS - 1),
                   $urandom_range(0, 7), {$urandom, $urandom});
        run_flush(1, 0, 1);
        for (int s = 0; s < SETS; s++)
            for (int t = 0; t < 8; t++) begin
                peek(s, t);
                check("inv_miss", 64'(hit), 64'd0);
            end

        // reset while a line is presented
        do_reset();
        access(0, 1, 1, 2, 40, {$urandom, $urandom});
        flush_req = 1;
        tick();
        flush_req = 0;
        wait_cyc = 0;
        while (!wb_if.wb_valid && wait_cyc < 100) begin
            tick();
            wait_cyc++;
        end
        check("t6_emit_reached", 64'(wb_if.wb_valid), 64'd1);
        #2;
        reset_n = 0;
        #1;
        check("t6_wb_valid_drop", 64'(wb_if.wb_valid), 64'd0);
        check("t6_busy_drop", 64'(flush_busy), 64'd0);
        check("t6_no_done", 64'(flush_done), 64'd0);
        tick();
        tick();
        reset_n = 1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            check("t6_no_done_after", 64'(flush_done), 64'd0);
            tick();
        end
        peek(2, 40);
        check("t6_miss", 64'(hit), 64'd0);
        access(1, 0, 0, 2, 40, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
